// File: rtl/ppc_types.sv
// ppc_types: SPR numbers, the SPR-number-to-entry map and the rename entry record
package ppc_types;
  localparam logic [9:0] XER = 10'd1;
  localparam logic [9:0] LR  = 10'd8;
  localparam logic [9:0] CTR = 10'd9;
  localparam int SPR_MAP_SIZE = 3;
  localparam logic [SPR_MAP_SIZE-1:0][9:0] SPR_MAP = {CTR, LR, XER};
  localparam int RS_ID_MAX_W = 16;
  typedef struct packed {
    logic                   value_valid;
    logic [31:0]            value;
    logic [RS_ID_MAX_W-1:0] rs_id;
  } spr_entry_t;
  localparam spr_entry_t SPR_RESET = '{value_valid: 1'b1, value: '0, rs_id: '0};
endpackage

// File: rtl/spr_addr_decode.sv
// spr_addr_decode: translates a 10-bit SPR number into an entry index plus hit flag
module spr_addr_decode import ppc_types::*; #(
  parameter int NUM_SPR = 3,
  parameter int IDX_W   = 2
) (
  input  logic [9:0]       addr_i,
  output logic [IDX_W-1:0] idx_o,
  output logic             hit_o
);
  // scan the table from the top down so the lowest matching slot wins
  always_comb begin
    idx_o = '0;
    hit_o = 1'b0;
    for (int i = NUM_SPR - 1; i >= 0; i--) begin
      if (addr_i == SPR_MAP[i]) begin
        idx_o = IDX_W'(i);
        hit_o = 1'b1;
      end
    end
  end
endmodule

// File: rtl/spr_rename_file.sv
// spr_rename_file: renamed SPR file with result-bus writes, dispatch updates and flush
module spr_rename_file import ppc_types::*; #(
  parameter int READ_PORTS  = 2,
  parameter int WRITE_PORTS = 2,
  parameter int RS_ID_WIDTH = 5,
  parameter int NUM_SPR     = 3
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [9:0]                   read_addr        [READ_PORTS],
  output logic                         read_value_valid [READ_PORTS],
  output logic [31:0]                  read_value       [READ_PORTS],
  output logic [RS_ID_WIDTH-1:0]       read_rs_id       [READ_PORTS],
  output logic                         read_addr_err    [READ_PORTS],
  input  logic                         write_enable     [WRITE_PORTS],
  input  logic [9:0]                   write_addr       [WRITE_PORTS],
  input  logic [31:0]                  write_value      [WRITE_PORTS],
  input  logic [RS_ID_WIDTH-1:0]       write_rs_id      [WRITE_PORTS],
  input  logic                         update_enable,
  input  logic [9:0]                   update_addr,
  input  logic [RS_ID_WIDTH-1:0]       update_rs_id,
  input  logic                         flush,
  output logic [$clog2(NUM_SPR+1)-1:0] pending_count
);
  localparam int IDX_W = NUM_SPR > 1 ? $clog2(NUM_SPR) : 1;
  localparam int PC_W  = $clog2(NUM_SPR + 1);
  spr_entry_t       entries_q [NUM_SPR];
  spr_entry_t       entries_d [NUM_SPR];
  logic [PC_W-1:0]  pending_q, pending_d;
  logic [IDX_W-1:0] rd_idx [READ_PORTS];
  logic             rd_hit [READ_PORTS];
  logic [IDX_W-1:0] wr_idx [WRITE_PORTS];
  logic             wr_hit [WRITE_PORTS];
  logic [IDX_W-1:0] up_idx;
  logic             up_hit;
  for (genvar r = 0; r < READ_PORTS; r++) begin : g_rd_dec
    spr_addr_decode #(.NUM_SPR(NUM_SPR), .IDX_W(IDX_W)) u_dec (
      .addr_i(read_addr[r]), .idx_o(rd_idx[r]), .hit_o(rd_hit[r]));
  end
  for (genvar w = 0; w < WRITE_PORTS; w++) begin : g_wr_dec
    spr_addr_decode #(.NUM_SPR(NUM_SPR), .IDX_W(IDX_W)) u_dec (
      .addr_i(write_addr[w]), .idx_o(wr_idx[w]), .hit_o(wr_hit[w]));
  end
  spr_addr_decode #(.NUM_SPR(NUM_SPR), .IDX_W(IDX_W)) u_up_dec (
    .addr_i(update_addr), .idx_o(up_idx), .hit_o(up_hit));
  // read ports: entry state, with a same-cycle tag-matching result forwarded into invalid entries
  always_comb begin
    for (int r = 0; r < READ_PORTS; r++) begin
      read_value_valid[r] = 1'b0;
      read_value[r]       = '0;
      read_rs_id[r]       = '0;
      read_addr_err[r]    = !rd_hit[r];
      if (rd_hit[r]) begin
        read_value_valid[r] = entries_q[rd_idx[r]].value_valid;
        read_value[r]       = entries_q[rd_idx[r]].value;
        read_rs_id[r]       = entries_q[rd_idx[r]].rs_id[RS_ID_WIDTH-1:0];
        for (int w = WRITE_PORTS - 1; w >= 0; w--) begin
          if (!entries_q[rd_idx[r]].value_valid && write_enable[w] && wr_hit[w] &&
              wr_idx[w] == rd_idx[r] && write_rs_id[w] == entries_q[rd_idx[r]].rs_id[RS_ID_WIDTH-1:0]) begin
            read_value_valid[r] = 1'b1;
            read_value[r]       = write_value[w];
          end
        end
      end
    end
  end
  // next state: qualifying write (lowest port wins), then update, with flush overriding both
  always_comb begin
    pending_d = '0;
    for (int e = 0; e < NUM_SPR; e++) begin
      entries_d[e] = entries_q[e];
      for (int w = WRITE_PORTS - 1; w >= 0; w--) begin
        if (write_enable[w] && wr_hit[w] && wr_idx[w] == IDX_W'(e) && !entries_q[e].value_valid &&
            write_rs_id[w] == entries_q[e].rs_id[RS_ID_WIDTH-1:0]) begin
          entries_d[e].value       = write_value[w];
          entries_d[e].value_valid = 1'b1;
        end
      end
      if (update_enable && up_hit && up_idx == IDX_W'(e)) begin
        entries_d[e].value_valid = 1'b0;
        entries_d[e].rs_id       = RS_ID_MAX_W'(update_rs_id);
      end
      if (flush) entries_d[e] = '{value_valid: 1'b1, value: entries_q[e].value, rs_id: '0};
      pending_d = pending_d + PC_W'(!entries_d[e].value_valid);
    end
  end
  // state and pending count registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int e = 0; e < NUM_SPR; e++) entries_q[e] <= SPR_RESET;
      pending_q <= '0;
    end else begin
      for (int e = 0; e < NUM_SPR; e++) entries_q[e] <= entries_d[e];
      pending_q <= pending_d;
    end
  end
  assign pending_count = pending_q;
endmodule

// File: tb/tb_spr_rename_file.sv
// tb_spr_rename_file: directed stimulus with a queued-expectation scoreboard
module tb_spr_rename_file;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [9:0]  read_addr        [2];
  logic        read_value_valid [2];
  logic [31:0] read_value       [2];
  logic [4:0]  read_rs_id       [2];
  logic        read_addr_err    [2];
  logic        write_enable     [2];
  logic [9:0]  write_addr       [2];
  logic [31:0] write_value      [2];
  logic [4:0]  write_rs_id      [2];
  logic        update_enable;
  logic [9:0]  update_addr;
  logic [4:0]  update_rs_id;
  logic        flush;
  logic [1:0]  pending_count;
  typedef struct {
    string       name;
    int          port;
    logic        v;
    logic [31:0] val;
    logic [4:0]  id;
    logic        err;
    logic [1:0]  pc;
  } exp_t;
  exp_t q[$];
  int   n_run = 0;
  int   n_fail = 0;
  spr_rename_file dut (
    .clk(clk), .rst(rst),
    .read_addr(read_addr), .read_value_valid(read_value_valid), .read_value(read_value),
    .read_rs_id(read_rs_id), .read_addr_err(read_addr_err),
    .write_enable(write_enable), .write_addr(write_addr), .write_value(write_value),
    .write_rs_id(write_rs_id),
    .update_enable(update_enable), .update_addr(update_addr), .update_rs_id(update_rs_id),
    .flush(flush), .pending_count(pending_count)
  );
  always #5 clk = ~clk;
  task automatic idle();
    for (int i = 0; i < 2; i++) begin
      write_enable[i] = 1'b0;
      write_addr[i]   = '0;
      write_value[i]  = '0;
      write_rs_id[i]  = '0;
    end
    update_enable = 1'b0;
    update_addr   = '0;
    update_rs_id  = '0;
    flush         = 1'b0;
  endtask
  task automatic rd(input string name, input int port, input logic v, input logic [31:0] val,
                    input logic [4:0] id, input logic err);
    exp_t e;
    e = '{name: name, port: port, v: v, val: val, id: id, err: err, pc: 2'd0};
    q.push_back(e);
  endtask
  task automatic pc(input string name, input logic [1:0] n);
    exp_t e;
    e = '{name: name, port: -1, v: 1'b0, val: '0, id: '0, err: 1'b0, pc: n};
    q.push_back(e);
  endtask
  task automatic wr(input int p, input logic [9:0] a, input logic [4:0] id, input logic [31:0] val);
    write_enable[p] = 1'b1;
    write_addr[p]   = a;
    write_rs_id[p]  = id;
    write_value[p]  = val;
  endtask
  task automatic upd(input logic [9:0] a, input logic [4:0] id);
    update_enable = 1'b1;
    update_addr   = a;
    update_rs_id  = id;
  endtask
  // monitor: samples between edges and drains every pending expectation
  initial begin
    forever begin
      @(negedge clk);
      #3;
      while (q.size() > 0) begin
        exp_t e;
        e = q.pop_front();
        n_run++;
        if (e.port < 0) begin
          if (pending_count !== e.pc) begin
            n_fail++;
            $display("FAIL %s: pending_count got %0d expected %0d", e.name, pending_count, e.pc);
          end
        end else if (read_value_valid[e.port] !== e.v || read_value[e.port] !== e.val ||
                     read_rs_id[e.port] !== e.id || read_addr_err[e.port] !== e.err) begin
          n_fail++;
          $display("FAIL %s: port%0d got v=%b val=%h id=%0d err=%b expected v=%b val=%h id=%0d err=%b",
                   e.name, e.port, read_value_valid[e.port], read_value[e.port], read_rs_id[e.port],
                   read_addr_err[e.port], e.v, e.val, e.id, e.err);
        end
      end
    end
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end
  initial begin
    idle();
    read_addr[0] = 10'd8;
    read_addr[1] = 10'd5;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    rd("reset_lr", 0, 1, 0, 0, 0); rd("unmapped", 1, 0, 0, 0, 1); pc("reset_pc", 0);
    @(negedge clk); idle(); read_addr[0] = 10'd9; upd(10'd9, 5'd3);
    rd("ctr_before_upd", 0, 1, 0, 0, 0);
    @(negedge clk); idle(); wr(1, 10'd9, 5'd3, 32'hDEADBEEF);
    rd("ctr_bypass", 0, 1, 32'hDEADBEEF, 3, 0); pc("pc_ctr_pend", 1);
    @(negedge clk); idle();
    rd("ctr_commit", 0, 1, 32'hDEADBEEF, 3, 0); pc("pc_ctr_done", 0);
    @(negedge clk); idle(); read_addr[0] = 10'd1; upd(10'd1, 5'd4);
    @(negedge clk); idle(); wr(0, 10'd1, 5'd7, 32'h99);
    rd("xer_tag_miss_nobyp", 0, 0, 0, 4, 0); pc("pc_xer", 1);
    @(negedge clk); idle();
    rd("xer_tag_miss", 0, 0, 0, 4, 0); pc("pc_xer_hold", 1);
    @(negedge clk); idle(); read_addr[0] = 10'd8; upd(10'd8, 5'd2);
    @(negedge clk); idle(); wr(0, 10'd8, 5'd2, 32'h11); wr(1, 10'd8, 5'd2, 32'h22);
    rd("lr_dual_bypass", 0, 1, 32'h11, 2, 0); pc("pc_lr_pend", 2);
    @(negedge clk); idle();
    rd("lr_dual_commit", 0, 1, 32'h11, 2, 0); pc("pc_lr_done", 1);
    @(negedge clk); idle(); wr(0, 10'd8, 5'd2, 32'h77);
    @(negedge clk); idle();
    rd("write_valid_ignored", 0, 1, 32'h11, 2, 0);
    @(negedge clk); idle(); read_addr[0] = 10'd9; upd(10'd9, 5'd2);
    @(negedge clk); idle(); wr(0, 10'd9, 5'd2, 32'h55); upd(10'd9, 5'd6);
    rd("ctr_wr_upd_bypass", 0, 1, 32'h55, 2, 0); pc("pc_ctr_pend2", 2);
    @(negedge clk); idle();
    rd("ctr_wr_upd", 0, 0, 32'h55, 6, 0); pc("pc_wr_upd", 2);
    @(negedge clk); idle(); read_addr[0] = 10'd8; read_addr[1] = 10'd1; upd(10'd8, 5'd5);
    @(negedge clk); idle();
    rd("lr_pend", 0, 0, 32'h11, 5, 0); rd("xer_pend", 1, 0, 0, 4, 0); pc("pc_all", 3);
    @(negedge clk); idle(); flush = 1'b1; upd(10'd1, 5'd9); wr(0, 10'd9, 5'd6, 32'hABCD);
    @(negedge clk); idle(); read_addr[0] = 10'd1; read_addr[1] = 10'd9;
    rd("flush_xer", 0, 1, 0, 0, 0); rd("flush_ctr", 1, 1, 32'h55, 0, 0); pc("pc_flush", 0);
    @(negedge clk); idle(); read_addr[0] = 10'd8; upd(10'd8, 5'd1);
    @(negedge clk); idle();
    rd("lr_pend2", 0, 0, 32'h11, 1, 0); pc("pc_pre_rst", 1);
    @(negedge clk); idle();
    #1 rst = 1'b1;
    rd("async_rst_lr", 0, 1, 0, 0, 0); rd("async_rst_ctr", 1, 1, 0, 0, 0); pc("pc_async_rst", 0);
    @(negedge clk); upd(10'd9, 5'd7);
    @(negedge clk); idle(); rst = 1'b0;
    rd("upd_in_rst_lost", 1, 1, 0, 0, 0); pc("pc_after_rst", 0);
    @(negedge clk); idle();
    rd("post_rst_ctr", 1, 1, 0, 0, 0);
    @(negedge clk);
    #5;
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
